cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception/interrupt controller that sequences the instruction fetch stage. It collects synchronous exception requests from the pipeline and external interrupt lines, and records EPC/Cause/Status. It drives the fetcher's handler-entry pulse, ERET redirect, EPC value and qualified freeze, and exposes an MFC0/MTC0 register port to the M stage.

---
 rtl/cp0_exc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller.
// Sequences the fetch stage through handler entry and ERET. It holds the
// SR/Cause/EPC/PRId registers and exposes an MFC0/MTC0 port to the M stage.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID = 32'h4652_0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [5:0]  hw_int,
  input  logic        eret_req,
  input  logic        freeze_in,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        goto_handler,
  output logic        eret,
  output logic [31:0] epc,
  output logic        freeze,
  output logic        flush
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_ENTRY,
    ST_HANDLER,
    ST_RETURN
  } state_e;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  state_e      state_q, state_d;
  logic        goto_q, eret_q, flush_q;

  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;

  logic        int_pend;
  logic        enter_first;   // RUN -> ENTRY
  logic        enter_nested;  // HANDLER -> ENTRY
  logic        leave_return;  // RETURN -> RUN
  logic [4:0]  entry_code;

  // Bits of the write data that no CP0 field stores.
  logic        unused_wdata;
  assign unused_wdata = ^{cp0_wdata[31:16], cp0_wdata[9:2]};

  assign int_pend = ie_q & ~exl_q & (|(im_q & ip_q));

  // Next-state decode. A pending exception always wins over ERET, and
  // interrupts are only taken from RUN.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    enter_first  = 1'b0;
    enter_nested = 1'b0;
    leave_return = 1'b0;
    entry_code   = exc_code;
    unique case (state_q)
      ST_RUN: begin
        if (exc_req) begin
          state_d     = ST_ENTRY;
          enter_first = 1'b1;
        end else if (int_pend) begin
          state_d     = ST_ENTRY;
          enter_first = 1'b1;
          entry_code  = 5'd0;
        end else if (eret_req) begin
          state_d = ST_RETURN;
        end
      end
      ST_ENTRY: state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (exc_req) begin
          state_d      = ST_ENTRY;
          enter_nested = 1'b1;
        end else if (eret_req) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        state_d      = ST_RUN;
        leave_return = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state plus registered redirect/flush pulses, decoded from the next state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= ST_RUN;
      goto_q  <= 1'b0;
      eret_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      goto_q  <= (state_d == ST_ENTRY);
      eret_q  <= (state_d == ST_RETURN);
      flush_q <= (state_d == ST_ENTRY) || (state_d == ST_RETURN);
    end
  end

  // CP0 registers. A hardware update of SR or EPC drops an MTC0 to it on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      ip_q <= hw_int;

      if (enter_first) begin
        exl_q <= 1'b1;
      end else if (leave_return) begin
        exl_q <= 1'b0;
      end else if (cp0_we && cp0_addr == ADDR_SR) begin
        im_q  <= cp0_wdata[15:10];
        exl_q <= cp0_wdata[1];
        ie_q  <= cp0_wdata[0];
      end

      if (enter_first) begin
        epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
      end else if (cp0_we && cp0_addr == ADDR_EPC) begin
        epc_q <= cp0_wdata;
      end

      if (enter_first || enter_nested) begin
        bd_q       <= exc_bd;
        exc_code_q <= entry_code;
      end
    end
  end

  // MFC0 read mux. Unimplemented addresses read zero.
  always_comb begin
    cp0_rdata = '0;
    unique case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID;
      default:    cp0_rdata = '0;
    endcase
  end

  assign goto_handler = goto_q;
  assign eret         = eret_q;
  assign flush        = flush_q;
  assign epc          = epc_q;
  assign freeze       = freeze_in & ~goto_q & ~eret_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [5:0]  hw_int;
  logic        eret_req;
  logic        freeze_in;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        goto_handler;
  logic        eret;
  logic [31:0] epc;
  logic        freeze;
  logic        flush;

  int n_checks = 0;
  int n_errors = 0;

  cp0_exc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .exc_req      (exc_req),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .hw_int       (hw_int),
    .eret_req     (eret_req),
    .freeze_in    (freeze_in),
    .cp0_we       (cp0_we),
    .cp0_addr     (cp0_addr),
    .cp0_wdata    (cp0_wdata),
    .cp0_rdata    (cp0_rdata),
    .goto_handler (goto_handler),
    .eret         (eret),
    .epc          (epc),
    .freeze       (freeze),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs and samples sit 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  task automatic check_pulses(input string tag, input logic g, input logic e, input logic f);
    check({tag, ".goto"}, {31'd0, goto_handler}, {31'd0, g});
    check({tag, ".eret"}, {31'd0, eret}, {31'd0, e});
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
  endtask

  initial begin
    reset = 1'b1; exc_req = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    hw_int = '0; eret_req = 1'b0; freeze_in = 1'b0; cp0_we = 1'b0;
    cp0_addr = '0; cp0_wdata = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check_pulses("rst", 1'b0, 1'b0, 1'b0);
    check("rst.freeze", {31'd0, freeze}, 32'd0);
    check_reg("rst.sr", 5'd12, 32'd0);
    check_reg("rst.cause", 5'd13, 32'd0);
    check_reg("rst.epc", 5'd14, 32'd0);
    check_reg("rst.prid", 5'd15, 32'h4652_0800);
    tick();
    check_reg("rst.addr0", 5'd0, 32'd0);
    freeze_in = 1'b1;
    #1 check("run.freeze_pass", {31'd0, freeze}, 32'd1);
    freeze_in = 1'b0;

    // Writes to Cause and PRId are ignored
    cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    tick();
    cp0_addr = 5'd15;
    tick();
    cp0_we = 1'b0;
    check_reg("wr.cause_ign", 5'd13, 32'd0);
    check_reg("wr.prid_ign", 5'd15, 32'h4652_0800);

    // Interrupt entry: SR = IM0 | IE, then raise hw_int[0]
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    tick();
    cp0_we = 1'b0;
    check_reg("int.sr_wr", 5'd12, 32'h0000_0401);
    exc_pc = 32'h0000_1000; exc_bd = 1'b0;
    hw_int = 6'b000001;
    tick();
    check_pulses("int.lat1", 1'b0, 1'b0, 1'b0);
    tick();
    check_pulses("int.entry", 1'b1, 1'b0, 1'b1);
    tick();
    check_pulses("int.handler", 1'b0, 1'b0, 1'b0);
    check_reg("int.cause", 5'd13, 32'h0000_0400);
    check_reg("int.sr", 5'd12, 32'h0000_0403);
    check_reg("int.epc", 5'd14, 32'h0000_1000);
    tick();
    check_pulses("int.masked", 1'b0, 1'b0, 1'b0);
    hw_int = '0;
    tick();
    // Leave the handler so the next exception enters from RUN
    eret_req = 1'b1;
    tick();
    eret_req = 1'b0;
    check_pulses("int.eret", 1'b0, 1'b1, 1'b1);
    tick();
    check_reg("int.sr_ret", 5'd12, 32'h0000_0401);

    // Synchronous exception in a delay slot
    exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_3010; exc_bd = 1'b1;
    tick();
    exc_req = 1'b0;
    check_pulses("exc.entry", 1'b1, 1'b0, 1'b1);
    tick();
    check_pulses("exc.handler", 1'b0, 1'b0, 1'b0);
    check_reg("exc.epc", 5'd14, 32'h0000_300C);
    check_reg("exc.cause", 5'd13, 32'h8000_0010);
    check_reg("exc.sr", 5'd12, 32'h0000_0403);

    // Nested exception: ExcCode and BD change, EPC and EXL hold
    exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h0000_5000; exc_bd = 1'b0;
    tick();
    exc_req = 1'b0;
    check_pulses("nest.entry", 1'b1, 1'b0, 1'b1);
    tick();
    check_reg("nest.cause", 5'd13, 32'h0000_0028);
    check_reg("nest.epc", 5'd14, 32'h0000_300C);
    check_reg("nest.sr", 5'd12, 32'h0000_0403);

    // ERET under stall; MTC0 EPC during RETURN lands after the pulse
    eret_req = 1'b1; freeze_in = 1'b1;
    tick();
    eret_req = 1'b0;
    check_pulses("ret.pulse", 1'b0, 1'b1, 1'b1);
    check("ret.freeze", {31'd0, freeze}, 32'd0);
    check("ret.epc", epc, 32'h0000_300C);
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h1234_5678;
    tick();
    cp0_we = 1'b0;
    check_pulses("ret.done", 1'b0, 1'b0, 1'b0);
    check("ret.freeze_back", {31'd0, freeze}, 32'd1);
    check("ret.epc_wr", epc, 32'h1234_5678);
    check_reg("ret.sr", 5'd12, 32'h0000_0401);
    freeze_in = 1'b0;

    // Exception, ERET and MTC0 EPC on the same edge: exception wins
    exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h0000_7000; exc_bd = 1'b0;
    eret_req = 1'b1;
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEC;
    tick();
    exc_req = 1'b0; eret_req = 1'b0; cp0_we = 1'b0;
    check_pulses("race.entry", 1'b1, 1'b0, 1'b1);
    check("race.epc", epc, 32'h0000_7000);
    tick();
    check_pulses("race.after", 1'b0, 1'b0, 1'b0);

    // Held exc_req: one pulse every two cycles
    exc_req = 1'b1; exc_code = 5'd12;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("b2b.%0d", i), {31'd0, goto_handler}, {31'd0, (i % 2) == 0});
    end
    exc_req = 1'b0;
    tick();

    // Reset during ENTRY aborts the pulse
    check("pre_rst.handler", {31'd0, goto_handler}, 32'd0);
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    check_pulses("rst_entry.pulse", 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_pulses("rst_entry.abort", 1'b0, 1'b0, 1'b0);
    check_reg("rst_entry.sr", 5'd12, 32'd0);
    check_reg("rst_entry.cause", 5'd13, 32'd0);
    check_reg("rst_entry.epc", 5'd14, 32'd0);
    tick();
    check_pulses("rst_entry.idle", 1'b0, 1'b0, 1'b0);
    // From RUN an ERET goes straight to RETURN
    eret_req = 1'b1;
    tick();
    eret_req = 1'b0;
    check_pulses("rst_entry.run", 1'b0, 1'b1, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
